aes_key_expand: RTL
===================

Name: aes_key_expand

Overview:
- Iterative AES-128 key schedule generator that sits directly upstream of aes_encrypt and feeds it round keys.
- It accepts one 128-bit cipher key and streams round keys 0..10 over a valid/ready interface, computing one new round key per accepted transfer.
- The FIPS-197 forward S-box is implemented internally as a combinational lookup, with four instances for SubWord.

Parameters:
- NR, 10, number of rounds; the block emits round keys 0..NR. Only 10 is supported.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin expansion; sampled only in IDLE.
- key_in  input  128  cipher key, byte 0 in bits [127:120]; sampled on accepted start.
- busy  output  1  high from the cycle after an accepted start until the final transfer.
- rk_valid  output  1  rk_out/rk_idx hold a valid round key.
- rk_ready  input  1  consumer accepts the key when rk_valid && rk_ready.
- rk_idx  output  4  round number of rk_out, 0..10.
- rk_out  output  128  round key, same byte order as key_in.
- done  output  1  one-cycle pulse the cycle after round key 10 is accepted.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM goes to IDLE.
  - busy=0, rk_valid=0, done=0, rk_idx=0, rk_out=0, internal Rcon register=8'h01.
  - Reset mid-expansion aborts immediately; no further keys are emitted.
- FSM states: IDLE, EMIT.
- IDLE:
  - start=1 at edge T loads key_in into the key register, sets rk_idx=0 and Rcon=01, and enters EMIT.
  - From cycle T+1: rk_valid=1, busy=1, rk_out=key_in.
  - start=0 keeps the FSM in IDLE.
- EMIT:
  - Stall: with rk_valid=1 and rk_ready=0, rk_out and rk_idx hold stable for any number of cycles.
  - Transfer with rk_idx<10: the register loads the next round key and rk_idx increments; rk_valid stays 1, giving back-to-back transfers at one per cycle.
  - Next round key: w0'=w0^SubWord(RotWord(w3))^{Rcon,24'h0}, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - After each transfer, Rcon advances xtime-style: 01,02,04,08,10,20,40,80,1B,36. Doubling 80 yields 1B via the 8'h1B reduction.
  - Transfer with rk_idx=10: go to IDLE; the next cycle has rk_valid=0, busy=0, done=1 for exactly one cycle.
- start while busy is ignored, with no effect on the ongoing sequence.
- start asserted in the same cycle as done (the FSM is already in IDLE) is accepted normally.
- Minimum latency:
  - start to round key 0 valid: 1 cycle.
  - start to done with rk_ready tied high: 12 cycles.
- All XOR/rotate operations are 32-bit word-wise with no width growth; Rcon is 8 bits.

Optional Feature:
- Macro: AES_KEY_CACHE_EN.
- Enabled:
  - Adds ports rd_idx (input 4) and rd_key (output 128).
  - Each round key is written into an 11x128 register file on its transfer.
  - rd_key = cache[rd_idx] combinationally; rd_idx>10 returns 0.
  - The cache clears to 0 on reset and is overwritten by a new expansion. Entries not yet re-written keep their old values until their round is transferred.
  - This lets aes_encrypt fetch keys by round without re-expanding.
- Disabled: no cache storage, no extra ports; round keys are available only via the stream.

Test Plan:
- FIPS-197 key: key_in=2b7e151628aed2a6abf7158809cf4f3c, start pulse, rk_ready=1.
  - Expect idx0=2b7e1516..4f3c, idx1=a0fafe1788542cb123a339392a6c7605, idx2=f2c295f27a96b9435935807a7359f67f, idx10=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Expect done 12 cycles after start.
- Backpressure: same key, rk_ready low for 5 cycles at idx 3 and random thereafter.
  - rk_out/rk_idx are stable during the stall; the full sequence matches the previous test; each index is transferred exactly once.
- Ignored start: pulse start with key_in=000102030405060708090a0b0c0d0e0f at idx 4 of a running expansion.
  - Sequence still ends with d014f9a8..0ca6.
- Back-to-back: start asserted in the done cycle with key_in=0.
  - New idx1=62636363626363636263636362636363; idx10=b4ef5bcb3e92e21123e951cf6f8f188e.
- Reset mid-operation: drop rst_n at idx 6.
  - All outputs go 0 asynchronously; after release, no rk_valid until the next start, then the correct sequence is emitted from idx 0.
- AES_KEY_CACHE_EN: after the FIPS expansion, rd_idx=1 gives a0fafe17..7605, rd_idx=10 gives d014f9a8..0ca6, rd_idx=15 gives 0.

Source files
------------

// File: rtl/aes_key_expand.sv
// aes_key_expand: iterative AES-128 key schedule streaming round keys 0..NR over valid/ready.
// Optional macro AES_KEY_CACHE_EN adds an 11-entry round-key cache readable via rd_idx/rd_key.

// Combinational FIPS-197 forward S-box lookup.
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    // Entry 0 sits in the most significant byte of the table.
    assign o_byte = SBOX[11'd2047 - {i_byte, 3'b000} -: 8];
endmodule

module aes_key_expand #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
`ifdef AES_KEY_CACHE_EN
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key,
`endif
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [3:0]   rk_idx,
    output logic [127:0] rk_out,
    output logic         done
);
    typedef enum logic {IDLE, EMIT} state_t;

    localparam logic [3:0] LAST = 4'(NR);

    state_t       r_state, w_state_next;
    logic [127:0] r_key;
    logic [3:0]   r_idx;
    logic [7:0]   r_rcon;
    logic         r_done;
    logic         w_xfer;
    logic [31:0]  w_rot, w_sub, w_w0, w_w1, w_w2, w_w3;
    logic [7:0]   w_rcon_next;

    assign w_xfer = (r_state == EMIT) && rk_ready;

    // RotWord of the last word feeds four S-box lookups (SubWord).
    assign w_rot = {r_key[23:0], r_key[31:24]};

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_sbox
            aes_sbox u_sbox (.i_byte(w_rot[8*g +: 8]), .o_byte(w_sub[8*g +: 8]));
        end
    endgenerate

    assign w_w0 = r_key[127:96] ^ w_sub ^ {r_rcon, 24'h0};
    assign w_w1 = r_key[95:64] ^ w_w0;
    assign w_w2 = r_key[63:32] ^ w_w1;
    assign w_w3 = r_key[31:0] ^ w_w2;

    // GF(2^8) doubling: 80 wraps to 1B through the reduction polynomial.
    assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Next state: start only matters in IDLE; leave EMIT after the last key is taken.
    always_comb begin
        w_state_next = r_state;
        if (r_state == IDLE && start)    w_state_next = EMIT;
        else if (w_xfer && r_idx == LAST) w_state_next = IDLE;
    end

    // Key, round index, Rcon and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key  <= '0;
            r_idx  <= '0;
            r_rcon <= 8'h01;
            r_done <= 1'b0;
        end else begin
            r_done <= w_xfer && r_idx == LAST;
            if (r_state == IDLE && start) begin
                r_key  <= key_in;
                r_idx  <= '0;
                r_rcon <= 8'h01;
            end else if (w_xfer && r_idx != LAST) begin
                r_key  <= {w_w0, w_w1, w_w2, w_w3};
                r_idx  <= r_idx + 4'd1;
                r_rcon <= w_rcon_next;
            end
        end
    end

    assign busy     = r_state == EMIT;
    assign rk_valid = r_state == EMIT;
    assign rk_idx   = r_idx;
    assign rk_out   = r_key;
    assign done     = r_done;

`ifdef AES_KEY_CACHE_EN
    logic [127:0] r_cache [0:10];

    // Capture each round key as it is handed to the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) for (int i = 0; i < 11; i++) r_cache[i] <= '0;
        else if (w_xfer) r_cache[r_idx] <= r_key;
    end

    assign rd_key = (rd_idx <= 4'd10) ? r_cache[rd_idx] : '0;
`endif
endmodule
